// File: rtl/register_file_pkg.sv
// Shared constants for the register file slice.
// Widths and the architecturally special GPR indices.
package register_file_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_ZERO   = 0;
  localparam int REG_V0     = 2;
endpackage

// File: rtl/register_file_if.sv
// Write/read bundle for a single enabled register (HI or LO).
// The master drives the write request; the slave returns the stored value.
interface register_file_if #(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH
);
  logic                  we;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output we,
    output wdata,
    input  rdata
  );

  modport slave (
    input  we,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/hilo_register.sv
// Enabled register with synchronous clear, used for HI and LO.
// Reset wins over the stall, matching the GPR array.
module hilo_register #(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  register_file_if.slave bus
);
  logic [DATA_WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (enable && bus.we) begin
      q <= bus.wdata;
    end
  end

  assign bus.rdata = q;
endmodule

// File: rtl/register_file.sv
// MIPS-style GPR file with HI/LO: two combinational read ports,
// one write port, no bypass; GPR[0] always reads as zero.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  hi_write_enable,
  input  logic                  lo_write_enable,
  input  logic [DATA_WIDTH-1:0] hi_write_data,
  input  logic [DATA_WIDTH-1:0] lo_write_data,
  output logic [DATA_WIDTH-1:0] hi_read_data,
  output logic [DATA_WIDTH-1:0] lo_read_data,
  output logic [DATA_WIDTH-1:0] register_v0
);
  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);
  localparam logic [ADDR_WIDTH-1:0] V0_IDX   = ADDR_WIDTH'(REG_V0);

  logic [DATA_WIDTH-1:0] gpr [NREGS];
  logic                  gpr_we;

  assign gpr_we = clk_enable && write_enable && (write_reg != ZERO_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        gpr[i] <= '0;
      end
    end else if (gpr_we) begin
      gpr[write_reg] <= write_data;
    end
  end

  // Index 0 is forced to zero at the port, independent of array contents.
  assign read_data1 = (read_reg1 == ZERO_IDX) ? '0 : gpr[read_reg1];
  assign read_data2 = (read_reg2 == ZERO_IDX) ? '0 : gpr[read_reg2];
  assign register_v0 = gpr[V0_IDX];

  register_file_if #(.DATA_WIDTH(DATA_WIDTH)) hi_bus ();
  register_file_if #(.DATA_WIDTH(DATA_WIDTH)) lo_bus ();

  assign hi_bus.we    = hi_write_enable;
  assign hi_bus.wdata = hi_write_data;
  assign lo_bus.we    = lo_write_enable;
  assign lo_bus.wdata = lo_write_data;

  hilo_register #(.DATA_WIDTH(DATA_WIDTH)) u_hi (
    .clk    (clk),
    .reset  (reset),
    .enable (clk_enable),
    .bus    (hi_bus.slave)
  );

  hilo_register #(.DATA_WIDTH(DATA_WIDTH)) u_lo (
    .clk    (clk),
    .reset  (reset),
    .enable (clk_enable),
    .bus    (lo_bus.slave)
  );

  assign hi_read_data = hi_bus.rdata;
  assign lo_read_data = lo_bus.rdata;
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of every GPR, HI and LO.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: GPR index width (32 registers).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port clk_enable  input  1: when low, no state changes (pipeline stall).
REQ-006 SHALL have port read_reg1  input  5: index of source operand A.
REQ-007 SHALL have port read_reg2  input  5: index of source operand B.
REQ-008 SHALL have port read_data1  output  32: GPR[read_reg1], drives ALU input A.
REQ-009 SHALL have port read_data2  output  32: GPR[read_reg2], drives ALU input B.
REQ-010 SHALL have port write_enable  input  1: GPR write request.
REQ-011 SHALL have port write_reg  input  5: GPR destination index.
REQ-012 SHALL have port write_data  input  32: GPR write value (ALU result, load data or link address).
REQ-013 SHALL have port hi_write_enable  input  1: HI write request.
REQ-014 SHALL have port lo_write_enable  input  1: LO write request.
REQ-015 SHALL have port hi_write_data  input  32: HI write value, connected to ALU HI_output.
REQ-016 SHALL have port lo_write_data  input  32: LO write value, connected to ALU LO_output.
REQ-017 SHALL have port hi_read_data  output  32: current HI, connected to ALU HI_input.
REQ-018 SHALL have port lo_read_data  output  32: current LO, connected to ALU LO_input.
REQ-019 SHALL have port register_v0  output  32: current GPR[2], for debug/result observation.

Function
REQ-020 Reads SHALL be combinational from stored state: zero-cycle latency, no clock involvement.
REQ-021 read_data1/read_data2 SHALL return 32'h0 whenever the index is 0, regardless of any write history.
REQ-022 A GPR write SHALL occur at a rising edge only when reset=0, clk_enable=1, write_enable=1 and write_reg!=0.
REQ-023 A write to index 0 SHALL be discarded; GPR[0] is constant 0.
REQ-024 No write-through bypass: a read of the register being written SHALL return the old value until after the edge (avoids a combinational loop through the ALU).
REQ-025 Both read ports SHALL be independent; identical indices on both ports SHALL return identical data.
REQ-026 HI SHALL load hi_write_data at a rising edge when reset=0, clk_enable=1 and hi_write_enable=1; LO likewise with lo_* signals.
REQ-027 HI, LO and GPR writes SHALL be independent and may all occur on the same edge (mult/div writes both HI and LO; mthi/mtlo writes one).
REQ-028 When clk_enable=0, all GPRs, HI and LO SHALL hold regardless of write enables.
REQ-029 register_v0 SHALL equal GPR[2] combinationally, following the same update timing as a read port.

Reset
REQ-030 At a rising edge with reset=1, all 32 GPRs, HI and LO SHALL clear to 32'h0, overriding every write enable and clk_enable.
REQ-031 After reset, read_data1, read_data2, hi_read_data, lo_read_data and register_v0 SHALL all be 32'h0.
REQ-032 Reset asserted mid-operation SHALL discard any write presented on that edge.

Structure
REQ-033 A shared package SHALL hold DATA_WIDTH, ADDR_WIDTH, REG_ZERO = 0 and REG_V0 = 2.
REQ-034 HI and LO SHALL each be one instance of sub-module hilo_register (32-bit enabled register with synchronous clear).

Verification
REQ-035 Reset, then read all indices -> every read_data, hi_read_data, lo_read_data, register_v0 = 0.
REQ-036 Write 32'h12345678 to reg 2, then read_reg1=2 -> read_data1=32'h12345678 and register_v0=32'h12345678 after the edge; read_data1 is still 0 before the edge.
REQ-037 Write 32'hFFFFFFFF to reg 0 -> read_data1 with read_reg1=0 stays 0.
REQ-038 hi_write_data=32'hCD2A258D, lo_write_data=32'hD9FF9643, both enables high for one edge -> hi_read_data/lo_read_data show those values; a following edge with only lo_write_enable and lo_write_data=32'h12345678 changes LO only.
REQ-039 clk_enable=0 with all write enables high and data 32'hA5A5A5A5 -> no register changes; reset=1 with clk_enable=0 -> all registers cleared.
REQ-040 Write reg 31 = 32'h8637DD9E and reg 1 = 32'h1 on consecutive edges -> read_reg1=31, read_reg2=1 return both values simultaneously.
